uart_rx_deserializer: RTL and testbench

//  Receive end of the lab serial link: samples an asynchronous 1-bit line, frames 8N1
//  (optionally 8E1) characters and presents each byte on a valid/ready output.

---
 rtl/uart_rx_deserializer.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 serial receiver: 2-FF synchronizer, bit-centre sampling FSM, 1-entry valid/ready holding register.
// Define UART_PARITY_EN to add an even-parity bit after the data bits (8E1 framing).
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 bit_tick_c;
  logic                 deliver_c;
`ifdef UART_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign bit_tick_c = (tick_q == TICK_LAST);

  // Synchronizer idles high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = bit_tick_c ? '0 : tick_q + TICK_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver_c   = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
`ifdef UART_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Half-bit check rejects glitches and re-aligns the counter to bit centres.
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick_c) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_tick_c) begin
          if ((^shift_q) != rx_s_q) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick_c) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
`ifdef UART_PARITY_EN
            deliver_c = ~par_bad_q;
`else
            deliver_c = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Holding register accepts a new byte when empty or being drained this cycle.
    if (deliver_c) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: directed frames push expected events, a monitor pops them.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;
  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;
  localparam int K_PERR = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
`ifdef UART_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_BYTE && e.kind == K_BYTE) check("byte_data", 32'(val), 32'(e.val));
    end
  endtask

  // Monitor samples mid-cycle; a valid&&ready seen here is the handshake on the next rising edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (frame_err || overrun || parity_err)
        check("single_err_pulse", 32'($countones({frame_err, overrun, parity_err})), 32'd1);
      if (frame_err)      observe(K_FERR, 8'h00);
      if (overrun)        observe(K_OVR, 8'h00);
      if (parity_err)     observe(K_PERR, 8'h00);
      if (valid && ready) observe(K_BYTE, data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ par_flip;
    tick(CPB);
`endif
    rx = stop_v;
    tick(CPB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, pending events %0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    rstn  = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    #1 rstn = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick(5);

    // Plain character.
    push(K_BYTE, 8'hA5);
    send(8'hA5, 1'b1);
    rx = 1'b1;
    tick(40);

    // Back-to-back with consumer stalled: second byte overruns.
    ready = 1'b0;
    push(K_OVR, 8'h00);
    push(K_BYTE, 8'h3C);
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b1);
    rx = 1'b1;
    tick(30);
    check("stalled_valid", 32'(valid), 32'd1);
    check("stalled_data", 32'(data), 32'h3C);
    ready = 1'b1;
    tick(2);
    check("valid_after_handshake", 32'(valid), 32'd0);
    tick(10);

    // Short low glitch is rejected.
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    check("glitch_valid", 32'(valid), 32'd0);

    // Bad stop bit then held-low line: one frame error, then recovery.
    push(K_FERR, 8'h00);
    push(K_BYTE, 8'h81);
    send(8'h55, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(20);
    send(8'h81, 1'b1);
    rx = 1'b1;
    tick(40);
    check("data_after_break", 32'(data), 32'h81);

    // Reset in the middle of a data bit abandons the character.
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h12 >> i);
      tick(CPB);
    end
    tick(5);
    rstn = 1'b0;
    rx   = 1'b1;
    tick(3);
    @(negedge clk);
    check("midframe_rst_valid", 32'(valid), 32'd0);
    check("midframe_rst_data", 32'(data), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick(20);
    push(K_BYTE, 8'h34);
    send(8'h34, 1'b1);
    rx = 1'b1;
    tick(40);

`ifdef UART_PARITY_EN
    // Wrong parity bit discards the byte; correct parity delivers it.
    push(K_PERR, 8'h00);
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    par_flip = 1'b0;
    rx = 1'b1;
    tick(20);
    push(K_BYTE, 8'h07);
    send(8'h07, 1'b1);
    rx = 1'b1;
    tick(40);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
